// File: rtl/tracklet_proc_sequencer.sv
// Window-based sequencer for the tracklet processing chain: accepts at most one
// event per window boundary, tracks per-stage occupancy and flags completions.
module tracklet_proc_sequencer #(
    parameter int PROC_CYCLES = 64,
    parameter int NSTAGES     = 6,
    parameter int BX_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ev_valid,
    output logic               ev_ready,
    output logic               en_proc,
    output logic               first_clk,
    output logic [BX_W-1:0]    bx,
    output logic [NSTAGES-1:0] stage_valid,
    output logic               done,
    output logic [BX_W-1:0]    done_bx,
    output logic [7:0]         bubble_cnt
);

    localparam int CNT_W = (PROC_CYCLES > 2) ? $clog2(PROC_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               boundary;
    logic               handshake;
    logic               cnt_last;
    logic [NSTAGES-1:0] shifted;

    assign boundary  = (state != IDLE) && (cnt == '0);
    assign ev_ready  = (state == RUN) && (cnt == '0);
    assign en_proc   = (state != IDLE);
    assign first_clk = boundary;
    assign handshake = ev_ready && ev_valid;
    assign cnt_last  = (cnt == CNT_W'(PROC_CYCLES - 1));
    assign shifted   = (stage_valid << 1) | NSTAGES'(handshake);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bx          <= '0;
            stage_valid <= '0;
            done        <= 1'b0;
            done_bx     <= '0;
            bubble_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state <= RUN;
                    end
                end
                default: begin
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                    if (cnt_last) begin
                        bx <= bx + 1'b1;
                    end
                    if (boundary) begin
                        // The event leaving the last stage was accepted NSTAGES windows ago.
                        if (stage_valid[NSTAGES-1]) begin
                            done    <= 1'b1;
                            done_bx <= bx - BX_W'(NSTAGES);
                        end
                        stage_valid <= shifted;
                        if ((state == RUN) && !handshake && (bubble_cnt != 8'hFF)) begin
                            bubble_cnt <= bubble_cnt + 1'b1;
                        end
                        if (state == RUN) begin
                            if (!start) begin
                                state <= DRAIN;
                            end
                        end else if (start) begin
                            state <= RUN;
                        end else if (shifted == '0) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tracklet_proc_sequencer.sv
// Self-checking bench for tracklet_proc_sequencer: window-level reference model,
// a table of scripted segments, hand-written corner sequences and random stimulus.
`timescale 1ns/1ps
module tb_tracklet_proc_sequencer;

    localparam int PC = 64;
    localparam int NS = 6;
    localparam int BW = 4;
    localparam int VW = 3 + BW + NS + 1 + BW + 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ev_valid;
    logic          ev_ready;
    logic          en_proc;
    logic          first_clk;
    logic [BW-1:0] bx;
    logic [NS-1:0] stage_valid;
    logic          done;
    logic [BW-1:0] done_bx;
    logic [7:0]    bubble_cnt;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int done_seen = 0;

    // Reference model: mode 0 idle, 1 run, 2 drain; the pipeline holds the
    // window number of acceptance per stage, or -1 for an empty stage.
    int m_mode, m_phase, m_win, m_bubbles, m_done_bx;
    int m_pipe[NS];
    bit m_done;

    typedef struct {
        bit s;
        int ev_mode;
        int ncyc;
        int exp_dones;
        bit exp_en;
        int exp_bubbles;
    } seg_t;

    always #2 clk = ~clk;

    tracklet_proc_sequencer #(.PROC_CYCLES(PC), .NSTAGES(NS), .BX_W(BW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .en_proc(en_proc),
        .first_clk(first_clk),
        .bx(bx),
        .stage_valid(stage_valid),
        .done(done),
        .done_bx(done_bx),
        .bubble_cnt(bubble_cnt)
    );

    function automatic void modelReset();
        m_mode = 0; m_phase = 0; m_win = 0; m_bubbles = 0; m_done_bx = 0; m_done = 0;
        for (int i = 0; i < NS; i++) m_pipe[i] = -1;
    endfunction

    function automatic void modelAdvance(bit s, bit ev);
        bit empty;
        m_done = 0;
        if (m_mode == 0) begin
            m_phase = 0;
            if (s) m_mode = 1;
            return;
        end
        if (m_phase == 0) begin
            if (m_pipe[NS-1] >= 0) begin
                m_done = 1;
                m_done_bx = m_pipe[NS-1];
            end
            for (int i = NS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = (m_mode == 1 && ev) ? (m_win % (1 << BW)) : -1;
            if (m_mode == 1 && !ev && m_bubbles < 255) m_bubbles++;
            empty = 1;
            for (int i = 0; i < NS; i++) if (m_pipe[i] >= 0) empty = 0;
            if (m_mode == 1) begin
                if (!s) m_mode = 2;
            end else if (s) begin
                m_mode = 1;
            end else if (empty) begin
                m_mode = 0;
                m_phase = 0;
                return;
            end
        end
        m_phase++;
        if (m_phase == PC) begin
            m_phase = 0;
            m_win++;
        end
    endfunction

    function automatic logic [VW-1:0] modelVec();
        logic [NS-1:0] sv;
        for (int i = 0; i < NS; i++) sv[i] = (m_pipe[i] >= 0);
        return {(m_mode == 1 && m_phase == 0), (m_mode != 0), (m_mode != 0 && m_phase == 0),
                BW'(m_win % (1 << BW)), sv, m_done, BW'(m_done_bx), 8'(m_bubbles)};
    endfunction

    task automatic checkOutput(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle, act, exp);
        end
    endtask

    task automatic compareAll(string name);
        logic [VW-1:0] act, exp;
        act = {ev_ready, en_proc, first_clk, bx, stage_valid, done, done_bx, bubble_cnt};
        exp = modelVec();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, exp);
        end
    endtask

    // One clock: model sees the inputs present at the edge, outputs compared on the falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        if (!reset) modelReset();
        else modelAdvance(start, ev_valid);
        @(negedge clk);
        cycle++;
        if (done) done_seen++;
        compareAll("model");
    endtask

    task automatic doReset();
        reset = 1'b0;
        #1;
        modelReset();
        compareAll("async_reset");
        start = 1'b0;
        ev_valid = 1'b0;
        repeat (3) applyStimulus();
        reset = 1'b1;
    endtask

    initial begin
        seg_t segs[4];
        int n;
        bit hs;
        bit pat[5];

        reset = 1'b0;
        start = 1'b0;
        ev_valid = 1'b0;
        @(negedge clk);

        // Single event: handshake, stage walk, completion latency.
        doReset();
        start = 1'b1;
        ev_valid = 1'b1;
        applyStimulus();
        checkOutput("single_ev_ready", int'(ev_ready), 1);
        checkOutput("single_first_clk", int'(first_clk), 1);
        applyStimulus();
        ev_valid = 1'b0;
        n = 1;
        while (!done && n < 450) begin
            applyStimulus();
            n++;
            if ((n % PC) == 32 && (n / PC) < NS)
                checkOutput("single_stage_walk", int'(stage_valid), 1 << (n / PC));
        end
        checkOutput("single_done_latency", n, NS * PC + 1);
        checkOutput("single_done_bx", int'(done_bx), 0);

        // Scripted segments from a fresh reset: idle, stream, drain, restart with bubbles.
        segs[0] = '{s: 1'b0, ev_mode: 0, ncyc: 200,         exp_dones: 0,  exp_en: 1'b0, exp_bubbles: 0};
        segs[1] = '{s: 1'b1, ev_mode: 1, ncyc: 1 + 21 * PC, exp_dones: 15, exp_en: 1'b1, exp_bubbles: 0};
        segs[2] = '{s: 1'b0, ev_mode: 0, ncyc: 2 * PC,      exp_dones: 2,  exp_en: 1'b1, exp_bubbles: 1};
        segs[3] = '{s: 1'b1, ev_mode: 2, ncyc: 8 * PC,      exp_dones: 5,  exp_en: 1'b1, exp_bubbles: 4};
        doReset();
        for (int k = 0; k < 4; k++) begin
            done_seen = 0;
            start = segs[k].s;
            for (int c = 0; c < segs[k].ncyc; c++) begin
                case (segs[k].ev_mode)
                    0: ev_valid = 1'b0;
                    1: ev_valid = 1'b1;
                    default: ev_valid = ((m_win % 2) == 0);
                endcase
                applyStimulus();
            end
            checkOutput($sformatf("seg%0d_dones", k), done_seen, segs[k].exp_dones);
            checkOutput($sformatf("seg%0d_en_proc", k), int'(en_proc), int'(segs[k].exp_en));
            checkOutput($sformatf("seg%0d_bubbles", k), int'(bubble_cnt), segs[k].exp_bubbles);
            if (k == 0) checkOutput("idle_bx", int'(bx), 0);
        end

        // Asynchronous reset mid-window with stage_valid = 011011.
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        doReset();
        start = 1'b1;
        applyStimulus();
        for (int w = 0; w < 4; w++) begin
            ev_valid = pat[w];
            repeat (PC) applyStimulus();
        end
        ev_valid = pat[4];
        repeat (30) applyStimulus();
        checkOutput("pre_reset_stage_valid", int'(stage_valid), 6'b011011);
        checkOutput("pre_reset_bx", int'(bx), 4);
        done_seen = 0;
        reset = 1'b0;
        #1;
        checkOutput("reset_now_vector",
                    int'({ev_ready, en_proc, first_clk, bx, stage_valid, done, done_bx, bubble_cnt}), 0);
        modelReset();
        start = 1'b0;
        ev_valid = 1'b0;
        repeat (5) applyStimulus();
        reset = 1'b1;
        start = 1'b1;
        applyStimulus();
        checkOutput("reset_no_done", done_seen, 0);
        checkOutput("restart_bx", int'(bx), 0);
        checkOutput("restart_first_clk", int'(first_clk), 1);

        // Bubble counter saturation.
        ev_valid = 1'b0;
        repeat (260 * PC) applyStimulus();
        checkOutput("bubble_saturate", int'(bubble_cnt), 255);

        // Randomised run against the model with held-until-accepted events.
        doReset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 149) == 0) start = ~start;
            if (!ev_valid && $urandom_range(0, 2) == 0) ev_valid = 1'b1;
            hs = (m_mode == 1 && m_phase == 0 && ev_valid);
            if ($urandom_range(0, 1999) == 0) begin
                doReset();
            end else begin
                applyStimulus();
                if (hs) ev_valid = 1'($urandom_range(0, 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
